// File: rtl/cmd_pkg.sv
// Shared command encoding for the dispatcher: opcodes, field positions,
// decoded command layout and the control FSM states.
package cmd_pkg;

  localparam logic [7:0] OP_HALT  = 8'h00;
  localparam logic [7:0] OP_FENCE = 8'hFF;

  localparam int OPC_LSB  = 56;
  localparam int SLOT_LSB = 52;
  localparam int CHAN_LSB = 48;
  localparam int ADDR_MSB = 47;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  slot;
    logic [3:0]  chan;
    logic [47:0] addr;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FENCE_WAIT,
    ST_HALTED
  } state_t;

  function automatic cmd_t decode_cmd(input logic [63:0] w);
    cmd_t c;
    c.opcode = w[OPC_LSB +: 8];
    c.slot   = w[SLOT_LSB +: 4];
    c.chan   = w[CHAN_LSB +: 4];
    c.addr   = w[ADDR_MSB:0];
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; head is visible combinationally.
// Pushes while full and pops while empty are ignored; flush empties it on the next edge.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = wr_en && !full;
  assign do_pop  = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// Command front-end: prefetch FIFO -> decode -> one-hot channel dispatch; cmd reaches ch_valid one edge after enqueue.
// Backpressure: a pending dispatch holds its payload until ch_ready; in_ready drops when the FIFO is full or halted.
module cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [63:0]       in_cmd,
  output logic              in_ready,
  output logic [NUM_CH-1:0] ch_valid,
  output logic [7:0]        ch_opcode,
  output logic [3:0]        ch_slot,
  output logic [ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH-1:0] ch_ready,
  input  logic [NUM_CH-1:0] ch_busy,
  output logic              halted,
  output logic              err_bad_ch,
  output logic [15:0]       dispatch_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH);

  state_t            state_q, state_d;
  logic              out_full_q, out_full_d;
  logic [NUM_CH-1:0] ch_valid_q, ch_valid_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [3:0]        slot_q, slot_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [63:0] fifo_rd_data;
  logic        fifo_full, fifo_empty;
  logic [CW:0] fifo_count;
  logic        pop, load, drop, flush;
  cmd_t        head;
  logic        head_vld, is_halt, is_fence, ch_ok, complete, slot_free;

  sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .wr_en   (in_valid && in_ready),
    .wr_data (in_cmd),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready  = !fifo_full && (state_q != ST_HALTED);
  assign head      = decode_cmd(fifo_rd_data);
  assign head_vld  = (fifo_count != '0) && !fifo_empty && (state_q == ST_RUN);
  assign is_halt   = (head.opcode == OP_HALT);
  assign is_fence  = (head.opcode == OP_FENCE);
  assign ch_ok     = ({1'b0, head.chan} < 5'(NUM_CH));
  assign complete  = |(ch_valid_q & ch_ready);
  // A pending dispatch finishing this edge frees the slot for the next head.
  assign slot_free = !out_full_q || complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (head_vld && is_halt && !out_full_q) state_d = ST_HALTED;
        else if (head_vld && is_fence)          state_d = ST_FENCE_WAIT;
      end
      ST_FENCE_WAIT: if (!out_full_q && (ch_busy == '0)) state_d = ST_RUN;
      default:       state_d = state_q;
    endcase
  end

  always_comb begin
    pop   = 1'b0;
    load  = 1'b0;
    drop  = 1'b0;
    flush = (state_q == ST_HALTED);
    if (head_vld) begin
      if (is_halt) begin
        flush = !out_full_q;
      end else if (is_fence) begin
        pop = 1'b1;
      end else if (!ch_ok) begin
        pop  = 1'b1;
        drop = 1'b1;
      end else if (slot_free) begin
        pop  = 1'b1;
        load = 1'b1;
      end
    end
  end

  always_comb begin
    out_full_d = out_full_q;
    ch_valid_d = ch_valid_q;
    opcode_d   = opcode_q;
    slot_d     = slot_q;
    addr_d     = addr_q;
    err_d      = drop;
    cnt_d      = cnt_q + 16'(complete);
    if (complete) begin
      out_full_d = 1'b0;
      ch_valid_d = '0;
    end
    if (load) begin
      out_full_d = 1'b1;
      for (int i = 0; i < NUM_CH; i++) ch_valid_d[i] = (32'(head.chan) == i);
      opcode_d   = head.opcode;
      slot_d     = head.slot;
      addr_d     = head.addr[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_full_q <= 1'b0;
      ch_valid_q <= '0;
      opcode_q   <= '0;
      slot_q     <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_full_q <= out_full_d;
      ch_valid_q <= ch_valid_d;
      opcode_q   <= opcode_d;
      slot_q     <= slot_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ch_valid     = ch_valid_q;
  assign ch_opcode    = opcode_q;
  assign ch_slot      = slot_q;
  assign ch_addr      = addr_q;
  assign halted       = (state_q == ST_HALTED);
  assign err_bad_ch   = err_q;
  assign dispatch_cnt = cnt_q;

endmodule
